// File: rtl/mult16.sv
// Sequential 16x16 shift-add multiplier returning the low 16 bits of A*B.
// One iteration per RUN cycle, 16 iterations, one-cycle DONE in FIN.

module And16 (
   input  logic [15:0] i_a,
   input  logic        i_b,
   output logic [15:0] o_y
);
   assign o_y = i_a & {16{i_b}};
endmodule

module Add16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_sum
);
   assign o_sum = i_a + i_b;
endmodule

module mult16 (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        READY,
   output logic        DONE,
   output logic [15:0] OUT
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_mcand;
   logic [15:0] r_mplier;
   logic [15:0] r_acc;
   logic [3:0]  r_count;
   logic        r_ready;
   logic        r_done;
   logic [15:0] r_out;
   logic [15:0] w_partial;
   logic [15:0] w_sum;

   And16 u_and (
      .i_a (r_mcand),
      .i_b (r_mplier[0]),
      .o_y (w_partial)
   );

   Add16 u_add (
      .i_a   (r_acc),
      .i_b   (w_partial),
      .o_sum (w_sum)
   );

   // Next-state decode; START only matters in IDLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_next_state = S_RUN;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_RUN: begin
            if (r_count == 4'd15) begin
               w_next_state = S_FIN;
            end else begin
               w_next_state = S_RUN;
            end
         end
         S_FIN:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= S_IDLE;
         r_mcand  <= 16'h0000;
         r_mplier <= 16'h0000;
         r_acc    <= 16'h0000;
         r_count  <= 4'd0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_out    <= 16'h0000;
      end else begin
         r_state <= w_next_state;
         r_ready <= (w_next_state == S_IDLE);
         r_done  <= (w_next_state == S_FIN);
         case (r_state)
            S_IDLE: begin
               if (START) begin
                  r_mcand  <= A;
                  r_mplier <= B;
                  r_acc    <= 16'h0000;
                  r_count  <= 4'd0;
               end
            end
            S_RUN: begin
               r_acc    <= w_sum;
               r_mcand  <= {r_mcand[14:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[15:1]};
               r_count  <= r_count + 4'd1;
               // Publish only the final sum so OUT never shows partial results.
               if (r_count == 4'd15) begin
                  r_out <= w_sum;
               end
            end
            S_FIN: begin
               r_count <= r_count;
            end
            default: begin
               r_count <= 4'd0;
            end
         endcase
      end
   end

   assign READY = r_ready;
   assign DONE  = r_done;
   assign OUT   = r_out;
endmodule

// File: tb/tb_mult16.sv
// Directed-vector bench for mult16 with hand-computed products and latency checks.

module tb_mult16;
   logic        CLK;
   logic        RESET;
   logic        START;
   logic [15:0] A;
   logic [15:0] B;
   logic        READY;
   logic        DONE;
   logic [15:0] OUT;

   int n_checks;
   int n_pass;

   mult16 dut (
      .CLK   (CLK),
      .RESET (RESET),
      .START (START),
      .A     (A),
      .B     (B),
      .READY (READY),
      .DONE  (DONE),
      .OUT   (OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs === exp) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 time unit later.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Runs one op; if poke_edge in 1..16, START with 9*9 is driven into that edge.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input logic [15:0] prev, input int poke_edge);
      int dones;
      dones = 0;
      A = a; B = b; START = 1'b1;
      tick();                     // edge 0
      START = 1'b0;
      A = ~a; B = ~b;             // operands must already be captured
      check({tag, "_ready_lo"}, READY, 1'b0);
      for (int e = 1; e <= 15; e++) begin
         if (e == poke_edge) begin
            START = 1'b1; A = 16'h0009; B = 16'h0009;
         end
         tick();
         START = 1'b0;
         if (DONE) dones++;
         if (e == 8) check({tag, "_out_hold"}, OUT, prev);
      end
      check({tag, "_no_early_done"}, dones, 0);
      if (poke_edge == 16) begin
         START = 1'b1; A = 16'h0009; B = 16'h0009;
      end
      tick();                     // edge 16
      START = 1'b0;
      check({tag, "_done"}, DONE, 1'b1);
      check({tag, "_out"}, OUT, exp);
      check({tag, "_ready_fin"}, READY, 1'b0);
      tick();                     // edge 17
      check({tag, "_done_pulse"}, DONE, 1'b0);
      check({tag, "_ready_back"}, READY, 1'b1);
      check({tag, "_out_kept"}, OUT, exp);
   endtask

   task automatic quiet(input string tag, input int cycles);
      int dones;
      int busy;
      dones = 0; busy = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (DONE) dones++;
         if (!READY) busy++;
      end
      check({tag, "_no_done"}, dones, 0);
      check({tag, "_stays_ready"}, busy, 0);
   endtask

   initial begin
      int   first_done;
      int   second_done;
      logic prev_done;
      int   double_done;
      n_checks = 0; n_pass = 0;
      RESET = 1'b1; START = 1'b0; A = 16'h0000; B = 16'h0000;
      tick(); tick();
      RESET = 1'b0;
      check("rst_ready", READY, 1'b1);
      check("rst_done", DONE, 1'b0);
      check("rst_out", OUT, 16'h0000);

      run_op("m3x5",   16'h0003, 16'h0005, 16'h000F, 16'h0000, 0);
      run_op("mffff",  16'hFFFF, 16'hFFFF, 16'h0001, 16'h000F, 0);
      run_op("mneg3",  16'hFFFD, 16'h0007, 16'hFFEB, 16'h0001, 0);
      run_op("mwrap",  16'h0100, 16'h0100, 16'h0000, 16'hFFEB, 0);
      run_op("mzero",  16'h1234, 16'h0000, 16'h0000, 16'h0000, 0);
      run_op("mbusy",  16'h0002, 16'h0003, 16'h0006, 16'h0000, 5);
      quiet("after_busy", 20);
      run_op("mfin",   16'h00AB, 16'h0010, 16'h0AB0, 16'h0006, 16);
      check("fin_start_ignored", READY, 1'b1);

      // START held high: operations 18 edges apart, DONE never doubled.
      first_done = -1; second_done = -1; double_done = 0; prev_done = 1'b0;
      A = 16'h0003; B = 16'h0005; START = 1'b1;
      for (int e = 0; e < 40; e++) begin
         tick();
         if (e == 17) begin
            A = 16'h0004; B = 16'h0007;
         end
         if (DONE && prev_done) double_done++;
         if (DONE && first_done < 0) begin
            first_done = e;
            check("b2b_out1", OUT, 16'h000F);
         end else if (DONE && second_done < 0) begin
            second_done = e;
            check("b2b_out2", OUT, 16'h001C);
         end
         prev_done = DONE;
      end
      START = 1'b0;
      check("b2b_first", first_done, 16);
      check("b2b_second", second_done, 34);
      check("b2b_single_pulse", double_done, 0);
      for (int i = 0; i < 40; i++) begin
         if (READY) break;
         tick();
      end
      tick();

      // Reset in the middle of RUN.
      A = 16'h0003; B = 16'h0005; START = 1'b1;
      tick();
      START = 1'b0;
      for (int e = 1; e < 8; e++) tick();
      RESET = 1'b1;
      tick();                     // edge 8
      RESET = 1'b0;
      check("abort_ready", READY, 1'b1);
      check("abort_done", DONE, 1'b0);
      check("abort_out", OUT, 16'h0000);
      quiet("abort", 20);
      check("abort_out_after", OUT, 16'h0000);

      // Reset and START on the same edge.
      RESET = 1'b1; START = 1'b1; A = 16'h0003; B = 16'h0005;
      tick();
      RESET = 1'b0; START = 1'b0;
      check("rst_start_ready", READY, 1'b1);
      quiet("rst_start", 20);
      check("rst_start_out", OUT, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
